// File: rtl/stream_merge_pkg.sv
// rtl/stream_merge_pkg.sv - shared types and constants for the stream merge arbiter
// Purpose: arbiter FSM state encoding, tag width helper, word counter width.
// Ports: none (package).
package stream_merge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam int WORD_COUNT_W = 32;

   // Ceiling log2 of the channel count, never less than one bit so a
   // single-channel build still has a legal tag field.
   function automatic int tag_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin request picker
// Purpose: choose the first requesting channel at or above ptr, wrapping modulo N_CH.
// Ports: req (per-channel request bits), ptr (search start index),
//        grant (chosen channel index), valid (any request present).
module rr_pick
   import stream_merge_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int TAG_W = tag_width(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [TAG_W-1:0] ptr,
   output logic [TAG_W-1:0] grant,
   output logic             valid
);

   logic [N_CH-1:0]  rot;
   logic [TAG_W-1:0] idx;
   int               ofs;

   always_comb begin
      rot   = '0;
      idx   = '0;
      ofs   = 0;
      valid = |req;
      // Rotate so that bit 0 of rot is the channel at ptr.
      for (int i = 0; i < N_CH; i++) begin
         idx    = TAG_W'((int'(ptr) + i) % N_CH);
         rot[i] = req[idx];
      end
      // Lowest set bit of the rotated vector is the winner's offset from ptr.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) ofs = i;
      end
      // Undo the rotation to get the absolute channel index.
      grant = TAG_W'((int'(ptr) + ofs) % N_CH);
   end

endmodule

// File: rtl/stream_merge_arbiter.sv
// rtl/stream_merge_arbiter.sv - round-robin merge of N_CH stb/ack streams into one tagged stream
// Purpose: grant one producer at a time, capture its word, present it tagged to a shared
//          sink; also aggregate per-process exception flags.
// Ports: clk, rst (sync, active-high); in_data/in_stb/in_ack per-channel input streams;
//        out_data/out_tag/out_stb/out_ack merged output stream; exception_in, exception,
//        exc_sticky, exc_src, exc_clr exception aggregation; word_count delivered words.
module stream_merge_arbiter
   import stream_merge_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = tag_width(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [N_CH-1:0]          in_stb,
   output logic [N_CH-1:0]          in_ack,
   output logic [DATA_W-1:0]        out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_stb,
   input  logic                     out_ack,
   input  logic [N_CH-1:0]          exception_in,
   output logic                     exception,
   output logic                     exc_sticky,
   output logic [TAG_W-1:0]         exc_src,
   input  logic                     exc_clr,
   output logic [WORD_COUNT_W-1:0]  word_count
);

   state_t                  state, state_n;
   logic [TAG_W-1:0]        grant_q, grant_n;
   logic [TAG_W-1:0]        rr_ptr, rr_ptr_n;
   logic [N_CH-1:0]         ack_n;
   logic                    stb_n;
   logic [DATA_W-1:0]       data_n;
   logic [TAG_W-1:0]        tag_n;
   logic [WORD_COUNT_W-1:0] count_n;
   logic [TAG_W-1:0]        pick_grant;
   logic                    pick_valid;
   logic                    sel_stb;
   logic [DATA_W-1:0]       sel_data;
   logic                    exc_hit;
   logic [TAG_W-1:0]        exc_low;

   rr_pick #(.N_CH(N_CH), .TAG_W(TAG_W)) u_pick (
      .req   (in_stb),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   always_comb begin
      state_n  = state;
      grant_n  = grant_q;
      rr_ptr_n = rr_ptr;
      ack_n    = '0;
      stb_n    = 1'b0;
      data_n   = out_data;
      tag_n    = out_tag;
      count_n  = word_count;
      sel_stb  = 1'b0;
      sel_data = '0;

      // Mux of the granted channel's strobe and data.
      for (int i = 0; i < N_CH; i++) begin
         if (grant_q == TAG_W'(i)) begin
            sel_stb  = in_stb[i];
            sel_data = in_data[i*DATA_W +: DATA_W];
         end
      end

      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_n = pick_grant;
               for (int i = 0; i < N_CH; i++) begin
                  if (pick_grant == TAG_W'(i)) ack_n[i] = 1'b1;
               end
               state_n = ACK;
            end
         end
         ACK: begin
            // in_ack is high this cycle, so a held strobe completes the input transfer.
            if (sel_stb) begin
               data_n  = sel_data;
               tag_n   = grant_q;
               stb_n   = 1'b1;
               state_n = SEND;
            end else begin
               // Producer withdrew: nothing captured, fairness pointer untouched.
               state_n = IDLE;
            end
         end
         SEND: begin
            if (out_ack) begin
               count_n  = word_count + WORD_COUNT_W'(1);
               rr_ptr_n = (int'(grant_q) == N_CH - 1) ? '0 : grant_q + TAG_W'(1);
               state_n  = IDLE;
            end else begin
               stb_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_q    <= '0;
         rr_ptr     <= '0;
         in_ack     <= '0;
         out_stb    <= 1'b0;
         out_data   <= '0;
         out_tag    <= '0;
         word_count <= '0;
      end else begin
         state      <= state_n;
         grant_q    <= grant_n;
         rr_ptr     <= rr_ptr_n;
         in_ack     <= ack_n;
         out_stb    <= stb_n;
         out_data   <= data_n;
         out_tag    <= tag_n;
         word_count <= count_n;
      end
   end

   always_comb begin
      exc_hit = |exception_in;
      exc_low = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (exception_in[i]) exc_low = TAG_W'(i);
      end
   end

   // A live exception beats a clear on the same edge and reloads the source index.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_sticky <= 1'b0;
         exc_src    <= '0;
      end else if (exc_hit && (!exc_sticky || exc_clr)) begin
         exc_sticky <= 1'b1;
         exc_src    <= exc_low;
      end else if (exc_clr) begin
         exc_sticky <= 1'b0;
         exc_src    <= '0;
      end
   end

   assign exception = exc_hit | exc_sticky;

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// tb/tb_stream_merge_arbiter.sv - directed scoreboard bench for stream_merge_arbiter
module tb_stream_merge_arbiter;

   localparam int N_CH   = 4;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_stb;
   logic [N_CH-1:0]        in_ack;
   logic [DATA_W-1:0]      out_data;
   logic [TAG_W-1:0]       out_tag;
   logic                   out_stb;
   logic                   out_ack;
   logic [N_CH-1:0]        exception_in;
   logic                   exception;
   logic                   exc_sticky;
   logic [TAG_W-1:0]       exc_src;
   logic                   exc_clr;
   logic [31:0]            word_count;

   stream_merge_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_stb       (in_stb),
      .in_ack       (in_ack),
      .out_data     (out_data),
      .out_tag      (out_tag),
      .out_stb      (out_stb),
      .out_ack      (out_ack),
      .exception_in (exception_in),
      .exception    (exception),
      .exc_sticky   (exc_sticky),
      .exc_src      (exc_src),
      .exc_clr      (exc_clr),
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_xfer = 0;
   int cyc    = 0;
   logic [33:0] exp_q[$];
   int          xfer_cyc[$];
   logic [33:0] exp_word;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change at negedge+1, so at negedge+2 out_stb/out_ack show what the next posedge will see.
   always begin
      @(negedge clk);
      #2;
      if (!rst && out_stb && out_ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_word: observed tag %0d data %h, expected no word", out_tag, out_data);
         end else begin
            exp_word = exp_q.pop_front();
            chk("out_tag", 64'(out_tag), 64'(exp_word[33:32]));
            chk("out_data", 64'(out_data), 64'(exp_word[31:0]));
         end
         xfer_cyc.push_back(cyc);
         n_xfer++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] tag, input logic [31:0] d);
      exp_q.push_back({tag, d});
   endtask

   task automatic set_data(input int ch, input logic [31:0] d);
      in_data[ch*DATA_W +: DATA_W] = d;
   endtask

   task automatic wait_xfer(input int target, input int budget);
      int k;
      k = 0;
      while (n_xfer < target && k < budget) begin
         step();
         k++;
      end
      chk("wait_xfer", 64'(n_xfer >= target), 64'd1);
   endtask

   int base;
   int wc0;

   initial begin
      rst          = 1'b1;
      in_data      = '0;
      in_stb       = '0;
      out_ack      = 1'b0;
      exception_in = '0;
      exc_clr      = 1'b0;
      repeat (3) step();

      chk("rst_in_ack", 64'(in_ack), 64'd0);
      chk("rst_out_stb", 64'(out_stb), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_exc_sticky", 64'(exc_sticky), 64'd0);
      chk("rst_exc_src", 64'(exc_src), 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
      chk("rst_exception", 64'(exception), 64'd0);
      rst = 1'b0;
      step();

      // Single channel, sink always ready.
      set_data(2, 32'hDEADBEEF);
      in_stb  = 4'b0100;
      out_ack = 1'b1;
      push(2'd2, 32'hDEADBEEF);
      step();
      chk("s1_in_ack", 64'(in_ack), 64'h4);
      chk("s1_out_stb_early", 64'(out_stb), 64'd0);
      step();
      chk("s1_out_stb", 64'(out_stb), 64'd1);
      chk("s1_out_tag", 64'(out_tag), 64'd2);
      chk("s1_out_data", 64'(out_data), 64'hDEADBEEF);
      chk("s1_in_ack_drop", 64'(in_ack), 64'd0);
      in_stb = '0;
      step();
      chk("s1_word_count", 64'(word_count), 64'd1);
      chk("s1_out_stb_done", 64'(out_stb), 64'd0);
      chk("s1_n_xfer", 64'(n_xfer), 64'd1);

      // All channels requesting continuously from rr_ptr=0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < N_CH; i++) set_data(i, 32'h10 + 32'(i));
      in_stb = 4'hF;
      base   = n_xfer;
      for (int k = 0; k < 6; k++) push(2'(k % 4), 32'h10 + 32'(k % 4));
      wait_xfer(base + 6, 40);
      in_stb = '0;
      if (xfer_cyc.size() >= base + 6) begin
         for (int k = 1; k < 6; k++)
            chk("s2_spacing", 64'(xfer_cyc[base+k] - xfer_cyc[base+k-1]), 64'd3);
      end
      step();
      step();
      chk("s2_word_count", 64'(word_count), 64'd6);
      chk("s2_idle", 64'(out_stb), 64'd0);

      // Sink stalls with ch1's word held; ch0 waits its turn.
      out_ack = 1'b0;
      set_data(1, 32'hA1A1A1A1);
      set_data(0, 32'hB0B0B0B0);
      in_stb = 4'b0010;
      push(2'd1, 32'hA1A1A1A1);
      push(2'd0, 32'hB0B0B0B0);
      wc0 = int'(word_count);
      step();
      chk("s3_in_ack", 64'(in_ack), 64'h2);
      step();
      in_stb = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         chk("s3_hold_stb", 64'(out_stb), 64'd1);
         chk("s3_hold_data", 64'(out_data), 64'hA1A1A1A1);
         chk("s3_hold_tag", 64'(out_tag), 64'd1);
         chk("s3_no_in_ack", 64'(in_ack), 64'd0);
         step();
      end
      out_ack = 1'b1;
      base    = n_xfer;
      wait_xfer(base + 2, 20);
      in_stb = '0;
      chk("s3_word_count", 64'(word_count), 64'(wc0 + 2));

      // Exception latch.
      step();
      exception_in = 4'b1010;
      #1;
      chk("s4_exception_comb", 64'(exception), 64'd1);
      chk("s4_sticky_pre", 64'(exc_sticky), 64'd0);
      step();
      chk("s4_sticky_set", 64'(exc_sticky), 64'd1);
      chk("s4_src_first", 64'(exc_src), 64'd1);
      exception_in = 4'b0001;
      step();
      chk("s4_sticky_keep", 64'(exc_sticky), 64'd1);
      chk("s4_src_keep", 64'(exc_src), 64'd1);
      exception_in = 4'b0000;
      #1;
      chk("s4_exception_held", 64'(exception), 64'd1);
      exc_clr = 1'b1;
      step();
      chk("s4_clr_sticky", 64'(exc_sticky), 64'd0);
      chk("s4_clr_src", 64'(exc_src), 64'd0);
      exc_clr = 1'b0;
      #1;
      chk("s4_exception_clear", 64'(exception), 64'd0);
      exc_clr      = 1'b1;
      exception_in = 4'b0100;
      step();
      chk("s4_setwins_sticky", 64'(exc_sticky), 64'd1);
      chk("s4_setwins_src", 64'(exc_src), 64'd2);
      exc_clr      = 1'b0;
      exception_in = 4'b0000;
      step();
      chk("s4_sticky_after", 64'(exc_sticky), 64'd1);
      exc_clr = 1'b1;
      step();
      exc_clr = 1'b0;
      chk("s4_final_clear", 64'(exc_sticky), 64'd0);

      // Reset while a ch3 word is waiting for the sink.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s5_pre_wc", 64'(word_count), 64'd0);
      set_data(3, 32'h33333333);
      in_stb  = 4'b1000;
      out_ack = 1'b0;
      push(2'd3, 32'h33333333);
      base = n_xfer;
      step();
      chk("s5_in_ack", 64'(in_ack), 64'h8);
      step();
      chk("s5_out_stb", 64'(out_stb), 64'd1);
      chk("s5_out_tag", 64'(out_tag), 64'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s5_rst_out_stb", 64'(out_stb), 64'd0);
      chk("s5_rst_in_ack", 64'(in_ack), 64'd0);
      chk("s5_rst_wc", 64'(word_count), 64'd0);
      chk("s5_rst_no_xfer", 64'(n_xfer), 64'(base));
      out_ack = 1'b1;
      step();
      chk("s5_regrant", 64'(in_ack), 64'h8);
      wait_xfer(base + 1, 20);
      in_stb = '0;
      chk("s5_wc_after", 64'(word_count), 64'd1);

      // ch0 withdraws during its ACK cycle.
      set_data(0, 32'h0C0C0C0C);
      in_stb = 4'b0001;
      base   = n_xfer;
      step();
      chk("s6_in_ack", 64'(in_ack), 64'h1);
      in_stb = '0;
      step();
      chk("s6_out_stb", 64'(out_stb), 64'd0);
      chk("s6_in_ack_drop", 64'(in_ack), 64'd0);
      step();
      chk("s6_word_count", 64'(word_count), 64'd1);
      chk("s6_no_xfer", 64'(n_xfer), 64'(base));
      set_data(1, 32'h1C1C1C1C);
      in_stb = 4'b0011;
      push(2'd0, 32'h0C0C0C0C);
      push(2'd1, 32'h1C1C1C1C);
      step();
      chk("s6_ptr_kept", 64'(in_ack), 64'h1);
      wait_xfer(base + 2, 20);
      in_stb = '0;
      chk("s6_word_count_final", 64'(word_count), 64'd3);

      step();
      step();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
